// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler for a shared 4-to-1 WIDTH-bit mux channel.
// Registered one-hot grant, select lines, and the registered selected lane data.
module mux4_rr_scheduler #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       grant,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state, state_nx;
  logic [1:0]       sel, sel_nx;
  logic [1:0]       last, last_nx;
  logic [HCW-1:0]   hold_cnt, hold_nx;
  logic [3:0]       grant_nx;
  logic             busy_nx;
  logic [WIDTH-1:0] lane_data;
  logic [2:0]       idle_pick;
  logic [2:0]       rel_pick;
  logic             release_now;

  // Returns {found, lane}: the first requesting lane after 'from', wrapping
  // so that 'from' itself is checked last.
  function automatic logic [2:0] pick(input logic [1:0] from, input logic [3:0] r);
    logic [1:0] idx;
    pick = '0;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = 2'(from + 2'(k));
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    case (sel)
      2'd0:    lane_data = i0;
      2'd1:    lane_data = i1;
      2'd2:    lane_data = i2;
      default: lane_data = i3;
    endcase
  end

  assign idle_pick   = pick(last, req);
  // On release the outgoing owner becomes 'last', so search from sel.
  assign rel_pick    = pick(sel, req);
  assign release_now = !req[sel] || (hold_cnt == HCW'(MAX_HOLD - 1));

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    last_nx  = last;
    hold_nx  = hold_cnt;
    grant_nx = grant;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        if (idle_pick[2]) begin
          state_nx = GRANT;
          sel_nx   = idle_pick[1:0];
          grant_nx = onehot(idle_pick[1:0]);
          hold_nx  = '0;
          busy_nx  = 1'b1;
        end
      end
      GRANT: begin
        if (!release_now) begin
          hold_nx = hold_cnt + HCW'(1);
        end else begin
          last_nx = sel;
          hold_nx = '0;
          if (rel_pick[2]) begin
            sel_nx   = rel_pick[1:0];
            grant_nx = onehot(rel_pick[1:0]);
          end else begin
            state_nx = IDLE;
            grant_nx = '0;
            busy_nx  = 1'b0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      last       <= 2'd3;
      hold_cnt   <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      last       <= last_nx;
      hold_cnt   <= hold_nx;
      grant      <= grant_nx;
      busy       <= busy_nx;
      data_out   <= lane_data;
      data_valid <= (state == GRANT) && req[sel];
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Randomized self-checking bench for mux4_rr_scheduler against a behavioural
// round-robin model (owner/last/tenure bookkeeping in plain integers).
module tb_mux4_rr_scheduler;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       req = '0;
  logic [WIDTH-1:0] lane [4];
  logic [WIDTH-1:0] i0, i1, i2, i3;
  logic [3:0]       grant;
  logic             s1, s0, busy, data_valid;
  logic [WIDTH-1:0] data_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               m_owner;   // -1 when idle
  int               m_last;
  int               m_tenure;  // cycles already served by current owner, minus 1
  int               m_sel;     // select lines hold their value while idle
  logic [3:0]       e_grant;
  logic [1:0]       e_sel;
  logic             e_busy;
  logic             e_dv;
  logic [WIDTH-1:0] e_dout;

  assign i0 = lane[0];
  assign i1 = lane[1];
  assign i2 = lane[2];
  assign i3 = lane[3];

  always #5 clock = ~clock;

  mux4_rr_scheduler #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .i0         (i0),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .grant      (grant),
    .s1         (s1),
    .s0         (s0),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  function automatic int next_owner(input int after, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(after + k) % 4]) return (after + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_tenure = 0; m_sel = 0;
    e_grant = '0; e_sel = '0; e_busy = 1'b0; e_dv = 1'b0; e_dout = '0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int w;
    e_dout = lane[m_sel];
    e_dv   = (m_owner >= 0) && r[m_sel];
    if (m_owner < 0) begin
      w = next_owner(m_last, r);
      if (w >= 0) begin m_owner = w; m_tenure = 0; end
    end else if (r[m_owner] && m_tenure + 1 < MAX_HOLD) begin
      m_tenure++;
    end else begin
      m_last = m_owner;
      w = next_owner(m_last, r);
      m_owner  = w;
      m_tenure = 0;
    end
    if (m_owner >= 0) m_sel = m_owner;
    e_busy  = (m_owner >= 0);
    e_grant = e_busy ? 4'(1 << m_owner) : 4'b0000;
    e_sel   = 2'(m_sel);
  endtask

  // Drive inputs, let one rising edge happen, advance the model, settle at negedge.
  task automatic step(input logic [3:0] r, input bit rnd_data);
    req = r;
    if (rnd_data)
      for (int k = 0; k < 4; k++) lane[k] = WIDTH'($urandom);
    @(posedge clock);
    model_edge(r);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, s1, s0, busy, data_valid} !== 8'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_values grant=%b s=%b%b busy=%b dv=%b dout=%h required all zero",
               grant, s1, s0, busy, data_valid, data_out);
    end
    step(4'b0000, 1);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req grant=%b busy=%b required 0000/0", grant, busy);
    end
  endtask

  task automatic test_single_lane();
    do_reset();
    step(4'b0000, 1);
    lane[0] = 8'h11; lane[1] = 8'h22; lane[2] = 8'hA5; lane[3] = 8'h33;
    step(4'b0100, 0);
    checks++;
    if (grant !== 4'b0100 || {s1, s0} !== 2'b10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant grant=%b s=%b%b busy=%b required 0100/10/1", grant, s1, s0, busy);
    end
    step(4'b0100, 0);
    checks++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_data dout=%h dv=%b required a5/1", data_out, data_valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 1);
      want = 4'(1 << ((k / MAX_HOLD) % 4));
      checks++;
      if (grant !== want || busy !== 1'b1) begin
        errors++;
        $display("FAIL rotation cyc=%0d grant=%b busy=%b required %b/1", k, grant, busy, want);
      end
      checks++;
      if (data_valid !== (k > 0) || data_out !== e_dout) begin
        errors++;
        $display("FAIL rotation_data cyc=%0d dv=%b dout=%h required %b/%h",
                 k, data_valid, data_out, (k > 0), e_dout);
      end
    end
  endtask

  task automatic test_persistent();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 1);
      checks++;
      if (grant !== 4'b0001 || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL persistent cyc=%0d grant=%b s=%b%b busy=%b required 0001/00/1",
                 k, grant, s1, s0, busy);
      end
    end
    step(4'b0000, 1);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL persistent_drop grant=%b busy=%b required 0000/0", grant, busy);
    end
    step(4'b0000, 1);
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL persistent_dv dv=%b required 0", data_valid);
    end
  endtask

  task automatic test_handover();
    do_reset();
    step(4'b0001, 1);
    step(4'b1001, 1);
    step(4'b1001, 1);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL handover_hold grant=%b required 0001", grant);
    end
    step(4'b1000, 1);
    checks++;
    if (grant !== 4'b1000 || {s1, s0} !== 2'b11 || busy !== 1'b1) begin
      errors++;
      $display("FAIL handover grant=%b s=%b%b busy=%b required 1000/11/1", grant, s1, s0, busy);
    end
  endtask

  task automatic test_priority_after_last1();
    do_reset();
    step(4'b0010, 1);
    step(4'b0000, 1);
    checks++;
    if (grant !== 4'b0000 || {s1, s0} !== 2'b01) begin
      errors++;
      $display("FAIL release_idle grant=%b s=%b%b required 0000/01", grant, s1, s0);
    end
    step(4'b1010, 1);
    checks++;
    if (grant !== 4'b1000 || {s1, s0} !== 2'b11) begin
      errors++;
      $display("FAIL priority_last1 grant=%b s=%b%b required 1000/11", grant, s1, s0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0100, 1);
    step(4'b0100, 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || data_valid !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL async_reset grant=%b busy=%b dv=%b dout=%h required all zero",
               grant, busy, data_valid, data_out);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(4'b1111, 1);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_priority grant=%b required 0001", grant);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      // Sticky requests with occasional churn give long tenures and releases.
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      step(r, 1);
      checks++;
      if (grant !== e_grant || {s1, s0} !== e_sel || busy !== e_busy ||
          data_valid !== e_dv || data_out !== e_dout) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b grant=%b s=%b%b busy=%b dv=%b dout=%h required %b/%b/%b/%b/%h",
                 k, r, grant, s1, s0, busy, data_valid, data_out,
                 e_grant, e_sel, e_busy, e_dv, e_dout);
      end
      checks++;
      if ((grant & (grant - 4'd1)) !== 4'd0 || busy !== (|grant)) begin
        errors++;
        $display("FAIL invariant cyc=%0d grant=%b busy=%b required onehot0 and busy==|grant",
                 k, grant, busy);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) lane[k] = '0;
    model_reset();
    test_reset();
    test_single_lane();
    test_rotation();
    test_persistent();
    test_handover();
    test_priority_after_last1();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_scheduler.md
Name: mux4_rr_scheduler

Overview:
Round-robin scheduler that shares a 4-input, WIDTH-bit multiplexed channel among four requesters. It arbitrates the request lines and drives the 2-bit select (s1, s0) plus a one-hot grant. It also registers the selected input data onto a single output channel with a valid flag. It sits in front of the gate-level 4-to-1 mux datapath, so the select lines are always sequenced and never driven ad hoc.

Parameters:
WIDTH, 8, data width of each input lane and of data_out.
MAX_HOLD, 4, maximum consecutive cycles one requester may keep the grant while others wait (legal range 1..255).

Ports:
clock  input  1  single system clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  4  request lines; req[k] belongs to lane k.
i0  input  WIDTH  lane 0 data.
i1  input  WIDTH  lane 1 data.
i2  input  WIDTH  lane 2 data.
i3  input  WIDTH  lane 3 data.
grant  output  4  registered one-hot grant, 0000 when idle.
s1  output  1  registered select MSB (lane index bit 1).
s0  output  1  registered select LSB (lane index bit 0).
busy  output  1  registered, high while in GRANT state.
data_out  output  WIDTH  registered selected lane data.
data_valid  output  1  registered, high when data_out carries a granted, requesting lane's data.

Behaviour:
- Clocking and reset: one clock domain. reset_n is asynchronous and active-low. All state clears immediately on assertion. Deassertion takes effect at the next rising edge.
- Reset values: grant=0000, s1=0, s0=0, busy=0, data_out=0, data_valid=0, state=IDLE, last=3, hold_cnt=0.
- State register: 2 states, IDLE and GRANT. Internal registers are sel[1:0] ({s1,s0}), last[1:0] (last released owner) and hold_cnt (width ceil(log2(MAX_HOLD))+1).
- Winner search: scan lanes last+1, last+2, last+3, last+4 (mod 4), and pick the first with req high. The previous owner is therefore lowest priority but eligible.
- IDLE, req==0000: stay in IDLE. grant=0000, busy=0.
- IDLE, any req high: at that edge go to GRANT. Set sel=winner, grant=onehot(winner), hold_cnt=0, busy=1. Latency is 1 edge from req sampled to grant visible.
- GRANT, req[sel]=1 and hold_cnt<MAX_HOLD-1: stay; hold_cnt+1.
- GRANT, release condition (req[sel]=0, or hold_cnt==MAX_HOLD-1): at that edge set last=sel, then re-run the winner search using the new last.
  - Winner found: switch directly to it in the same edge, with no idle bubble. Set hold_cnt=0.
  - No winner: go to IDLE. Set grant=0000 and busy=0; s1/s0 hold their last value.
- Single persistent requester: at MAX_HOLD expiry it re-wins itself. grant stays constant and hold_cnt restarts at 0.
- Datapath, every edge: data_out <= lane[sel] data (pre-edge sel); data_valid <= (state==GRANT && req[sel]). data_out is therefore 1 cycle behind grant.
- When data_valid=0, data_out still updates with the selected lane but is don't-care to consumers.
- req changes on non-owner lanes never disturb the current grant before its release condition.
- Invariants: grant is always one-hot or zero. grant==onehot({s1,s0}) whenever busy=1. busy==|grant.
- Reset mid-grant: outputs drop to reset values asynchronously. After release, arbitration restarts from last=3, so lane 0 has top priority.

Test Plan:
1. Reset, then req=0100 from cycle 2, i2=8'hA5 -> next edge: grant=0100, {s1,s0}=10, busy=1. One edge later: data_out=8'hA5, data_valid=1.
2. req=1111 held, MAX_HOLD=4 -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles. No cycle with grant=0000; data_valid continuously 1 after the first.
3. req=0001 held 20 cycles -> grant stays 0001 throughout and hold_cnt wraps 0..3 repeatedly. req drops -> next edge grant=0000, busy=0; one edge later data_valid=0.
4. Owner lane 0 granted; req=1001 for 2 cycles, then req=1000 -> at the edge sampling req[0]=0, grant=1000 and {s1,s0}=11. No idle cycle.
5. last=1 (lane 1 just released), req=1010 -> winner lane 3 (priority order 2,3,0,1). grant=1000.
6. During GRANT on lane 2, pulse reset_n low mid-cycle -> grant/busy/data_valid/data_out go to 0 without a clock edge. After release with req=1111, the first grant is 0001.
